// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master, three-slave round-robin bus arbiter with start timeout.
// Grants are registered and held for a whole transaction; RELEASE gives one idle turnaround cycle.
module bus_arbiter #(
    parameter int START_TIMEOUT = 16,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] m_req,
    input  logic [1:0] m0_slave_id,
    input  logic [1:0] m1_slave_id,
    input  logic [1:0] m_valid,
    input  logic [2:0] s_ready,
    output logic [1:0] m_grant,
    output logic [2:0] s_sel,
    output logic       bus_busy,
    output logic       owner,
    output logic       timeout_err,
    output logic       addr_err
);
    typedef enum logic [1:0] {IDLE, GRANTED, BUSY, RELEASE} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             last_owner, last_owner_n;
    logic             owner_n;
    logic [1:0]       m_grant_n;
    logic [2:0]       s_sel_n;
    logic             bus_busy_n, timeout_err_n, addr_err_n;
    logic             win;
    logic [1:0]       win_id;
    logic             handshake;

    assign win       = &m_req ? ~last_owner : m_req[1];
    assign win_id    = win ? m1_slave_id : m0_slave_id;
    // s_sel is all-zero for the unmapped id, so no handshake can ever start there
    assign handshake = m_valid[owner] & |(s_sel & s_ready);

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        last_owner_n  = last_owner;
        owner_n       = owner;
        m_grant_n     = m_grant;
        s_sel_n       = s_sel;
        bus_busy_n    = bus_busy;
        addr_err_n    = addr_err;
        timeout_err_n = 1'b0;
        case (state)
            IDLE: if (|m_req) begin
                state_n    = GRANTED;
                owner_n    = win;
                cnt_n      = '0;
                m_grant_n  = win ? 2'b10 : 2'b01;
                s_sel_n    = &win_id ? 3'b000 : 3'b001 << win_id;
                bus_busy_n = 1'b1;
                addr_err_n = &win_id;
            end
            GRANTED: begin
                if (!m_req[owner]) state_n = RELEASE;
                else if (handshake) state_n = BUSY;
                else if (cnt == CNT_W'(START_TIMEOUT - 1)) begin
                    state_n       = RELEASE;
                    timeout_err_n = 1'b1;
                end else cnt_n = &cnt ? cnt : cnt + 1'b1;
            end
            BUSY: if (!m_req[owner]) state_n = RELEASE;
            RELEASE: begin
                last_owner_n = owner;
                state_n      = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (state_n == RELEASE) begin
            m_grant_n  = 2'b00;
            s_sel_n    = 3'b000;
            bus_busy_n = 1'b0;
            addr_err_n = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            last_owner  <= 1'b1;
            owner       <= 1'b0;
            m_grant     <= 2'b00;
            s_sel       <= 3'b000;
            bus_busy    <= 1'b0;
            timeout_err <= 1'b0;
            addr_err    <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            last_owner  <= last_owner_n;
            owner       <= owner_n;
            m_grant     <= m_grant_n;
            s_sel       <= s_sel_n;
            bus_busy    <= bus_busy_n;
            timeout_err <= timeout_err_n;
            addr_err    <= addr_err_n;
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: scoreboard bench for bus_arbiter; each output vector is
// {m_grant, s_sel, bus_busy, owner, timeout_err, addr_err}.
module tb_bus_arbiter;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] m_req = '0;
    logic [1:0] m0_slave_id = '0;
    logic [1:0] m1_slave_id = '0;
    logic [1:0] m_valid = '0;
    logic [2:0] s_ready = '0;
    logic [1:0] m_grant;
    logic [2:0] s_sel;
    logic       bus_busy, owner, timeout_err, addr_err;

    int n_tests = 0;
    int n_fail  = 0;
    logic [8:0] exp_q[$];

    bus_arbiter #(.START_TIMEOUT(16), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .m_req(m_req),
        .m0_slave_id(m0_slave_id), .m1_slave_id(m1_slave_id),
        .m_valid(m_valid), .s_ready(s_ready),
        .m_grant(m_grant), .s_sel(s_sel), .bus_busy(bus_busy),
        .owner(owner), .timeout_err(timeout_err), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [8:0] v(logic [1:0] g, logic [2:0] s, logic b, logic o, logic t, logic a);
        return {g, s, b, o, t, a};
    endfunction

    function automatic logic [8:0] obs();
        return {m_grant, s_sel, bus_busy, owner, timeout_err, addr_err};
    endfunction

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic [1:0] req, input logic [1:0] id0,
                        input logic [1:0] id1, input logic [1:0] vld, input logic [2:0] rdy,
                        input logic [8:0] exp);
        m_req = req; m0_slave_id = id0; m1_slave_id = id1; m_valid = vld; s_ready = rdy;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) check({tag, " empty"}, obs(), 9'bx);
        else check(tag, obs(), exp_q.pop_front());
    endtask

    task automatic do_reset();
        m_req = '0; m_valid = '0; s_ready = '0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        check("reset", obs(), '0);
        reset = 1'b0;
        // single requester, handshake, burst, release
        step("s1_grant", 2'b01, 2'd2, 2'd0, 2'b01, 3'b100, v(2'b01, 3'b100, 1, 0, 0, 0));
        step("s1_busy",  2'b01, 2'd2, 2'd0, 2'b01, 3'b100, v(2'b01, 3'b100, 1, 0, 0, 0));
        step("s1_hold",  2'b01, 2'd2, 2'd0, 2'b00, 3'b000, v(2'b01, 3'b100, 1, 0, 0, 0));
        step("s1_rel",   2'b00, 2'd2, 2'd0, 2'b00, 3'b000, v(2'b00, 3'b000, 0, 0, 0, 0));
        step("s1_idle",  2'b00, 2'd2, 2'd0, 2'b00, 3'b000, v(2'b00, 3'b000, 0, 0, 0, 0));
        // strict alternation from reset
        do_reset();
        step("rr_g0",    2'b11, 2'd0, 2'd1, 2'b00, 3'b000, v(2'b01, 3'b001, 1, 0, 0, 0));
        step("rr_b0",    2'b11, 2'd0, 2'd1, 2'b01, 3'b001, v(2'b01, 3'b001, 1, 0, 0, 0));
        step("rr_r0",    2'b10, 2'd0, 2'd1, 2'b00, 3'b000, v(2'b00, 3'b000, 0, 0, 0, 0));
        step("rr_i0",    2'b11, 2'd0, 2'd1, 2'b00, 3'b000, v(2'b00, 3'b000, 0, 0, 0, 0));
        step("rr_g1",    2'b11, 2'd0, 2'd1, 2'b00, 3'b000, v(2'b10, 3'b010, 1, 1, 0, 0));
        step("rr_b1",    2'b11, 2'd0, 2'd1, 2'b10, 3'b010, v(2'b10, 3'b010, 1, 1, 0, 0));
        step("rr_r1",    2'b01, 2'd0, 2'd1, 2'b00, 3'b000, v(2'b00, 3'b000, 0, 1, 0, 0));
        step("rr_i1",    2'b11, 2'd0, 2'd1, 2'b00, 3'b000, v(2'b00, 3'b000, 0, 1, 0, 0));
        step("rr_g2",    2'b11, 2'd0, 2'd1, 2'b00, 3'b000, v(2'b01, 3'b001, 1, 0, 0, 0));
        step("rr_r2",    2'b10, 2'd0, 2'd1, 2'b00, 3'b000, v(2'b00, 3'b000, 0, 0, 0, 0));
        step("rr_i2",    2'b00, 2'd0, 2'd1, 2'b00, 3'b000, v(2'b00, 3'b000, 0, 0, 0, 0));
        // start timeout on master 1: grant visible for exactly 16 cycles
        step("to_g", 2'b10, 2'd3, 2'd1, 2'b00, 3'b111, v(2'b10, 3'b010, 1, 1, 0, 0));
        for (int i = 1; i < 16; i++)
            step($sformatf("to_hold%0d", i), 2'b10, 2'd3, 2'd1, 2'b00, 3'b111, v(2'b10, 3'b010, 1, 1, 0, 0));
        step("to_err",  2'b11, 2'd3, 2'd1, 2'b00, 3'b111, v(2'b00, 3'b000, 0, 1, 1, 0));
        step("to_idle", 2'b11, 2'd3, 2'd1, 2'b00, 3'b111, v(2'b00, 3'b000, 0, 1, 0, 0));
        // master 0 wins after master 1 timed out, targeting unmapped slave 3
        step("ae_g", 2'b11, 2'd3, 2'd1, 2'b01, 3'b111, v(2'b01, 3'b000, 1, 0, 0, 1));
        for (int i = 1; i < 16; i++)
            step($sformatf("ae_hold%0d", i), 2'b01, 2'd3, 2'd1, 2'b01, 3'b111, v(2'b01, 3'b000, 1, 0, 0, 1));
        step("ae_to",   2'b01, 2'd3, 2'd1, 2'b01, 3'b111, v(2'b00, 3'b000, 0, 0, 1, 0));
        step("ae_idle", 2'b00, 2'd3, 2'd1, 2'b00, 3'b000, v(2'b00, 3'b000, 0, 0, 0, 0));
        // slave id and non-owner valid ignored once BUSY
        step("bz_g",  2'b01, 2'd1, 2'd0, 2'b01, 3'b010, v(2'b01, 3'b010, 1, 0, 0, 0));
        step("bz_b",  2'b01, 2'd1, 2'd0, 2'b01, 3'b010, v(2'b01, 3'b010, 1, 0, 0, 0));
        step("bz_id", 2'b11, 2'd2, 2'd0, 2'b11, 3'b111, v(2'b01, 3'b010, 1, 0, 0, 0));
        step("bz_v1", 2'b11, 2'd2, 2'd0, 2'b10, 3'b111, v(2'b01, 3'b010, 1, 0, 0, 0));
        // asynchronous reset mid-burst
        reset = 1'b1;
        #1;
        check("async_rst", obs(), '0);
        @(posedge clk);
        #1;
        check("rst_hold", obs(), '0);
        reset = 1'b0;
        step("pr_g", 2'b11, 2'd2, 2'd0, 2'b00, 3'b000, v(2'b01, 3'b100, 1, 0, 0, 0));
        // request drop beats a same-cycle handshake
        step("pr_drop", 2'b10, 2'd2, 2'd0, 2'b01, 3'b100, v(2'b00, 3'b000, 0, 0, 0, 0));
        step("pr_idle", 2'b10, 2'd2, 2'd0, 2'b00, 3'b000, v(2'b00, 3'b000, 0, 0, 0, 0));
        step("pr_g1",   2'b10, 2'd2, 2'd0, 2'b00, 3'b000, v(2'b10, 3'b001, 1, 1, 0, 0));
        if (exp_q.size() != 0) check("queue_drain", 9'(exp_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
